// File: rtl/writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module   : writeback_regfile
// Purpose  : Writeback stage and 32 x DATA_W register file. Each accepted
//            EX_WB bundle is held for one cycle in a pipeline register, then
//            committed to the register file. The module also counts retired
//            instructions and keeps a sticky halt flag. Two independent,
//            combinational read ports serve decode.
// Options  : define WB_BYPASS_EN to forward the pending write to the read
//            ports ahead of commit. Without it, decode stalls on wb_pending.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [180:0]      EX_WB,
  input  logic [4:0]        rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [4:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              halted,
  output logic [31:0]       retired_count,
  output logic              wb_pending
);

  // Opcode field values. c_OP_HALT is the only opcode with side effects
  // beyond the register write.
  localparam logic [15:0] c_OP_HALT = 16'h000E;

  // ---------------------------------------------------------------------
  // Bundle field extraction
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] w_ex_data;
  logic [4:0]        w_ex_addr;
  logic              w_ex_valid;
  logic [15:0]       w_ex_op;

  assign w_ex_data  = EX_WB[DATA_W-1:0];
  assign w_ex_addr  = EX_WB[68:64];
  assign w_ex_valid = EX_WB[69];
  assign w_ex_op    = EX_WB[85:70];

  // The rest of the bundle belongs to earlier stages and is deliberately
  // ignored here. It is folded into one bit so that the gap is explicit.
  logic w_unused_ex;
  assign w_unused_ex = ^{EX_WB[180:86], EX_WB[63:DATA_W]};

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] r_regs [NREGS];
  logic [DATA_W-1:0] r_wb_data;
  logic [4:0]        r_wb_addr;
  logic              r_wb_we;
  logic              r_halted;
  logic [31:0]       r_retired_count;

  // ---------------------------------------------------------------------
  // Opcode classification
  // ---------------------------------------------------------------------
  logic w_op_writes;
  logic w_op_halt;
  logic w_accept;
  logic w_capture_we;

  // Decode the opcode class. Undefined opcodes fall through as non-writing.
  always_comb begin
    w_op_writes = 1'b0;
    case (w_ex_op)
      16'h0001, 16'h0002, 16'h0003, 16'h0004,
      16'h0005, 16'h0006, 16'h0007, 16'h0008,
      16'h000B, 16'h000C, 16'h000D: w_op_writes = 1'b1;
      default:                      w_op_writes = 1'b0;
    endcase
  end

  assign w_op_halt = (w_ex_op == c_OP_HALT);

  // Once halted, every incoming bundle is dropped: no capture and no count.
  assign w_accept = w_ex_valid && !r_halted;

  // Writes to r0 are discarded at capture. This keeps r0 out of both the
  // commit path and the bypass compare.
  assign w_capture_we = w_op_writes && (w_ex_addr != 5'd0);

  // ---------------------------------------------------------------------
  // Writeback pipeline register, retire counter and halt flag
  // ---------------------------------------------------------------------
  // Capture accepted bundles. Without a capture, the write enable drops so
  // that each write commits only once.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wb_data       <= '0;
      r_wb_addr       <= '0;
      r_wb_we         <= 1'b0;
      r_halted        <= 1'b0;
      r_retired_count <= '0;
    end else if (w_accept) begin
      r_wb_data       <= w_ex_data;
      r_wb_addr       <= w_ex_addr;
      r_wb_we         <= w_capture_we;
      r_retired_count <= r_retired_count + 32'd1;
      if (w_op_halt) begin
        r_halted <= 1'b1;
      end
    end else begin
      r_wb_we <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------
  // Commit the pending write. This runs on the same edge as a new capture
  // and is not blocked by halt. Reset drops a pending write.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (r_wb_we) begin
      r_regs[r_wb_addr] <= r_wb_data;
    end
  end

  // ---------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;

  // Port A: r0 reads as zero. With bypass enabled, the pending write
  // takes priority over the stored value.
  always_comb begin
    w_rd_a = '0;
    if (rd_addr_a != 5'd0) begin
      w_rd_a = r_regs[rd_addr_a];
`ifdef WB_BYPASS_EN
      if (r_wb_we && (r_wb_addr == rd_addr_a)) begin
        w_rd_a = r_wb_data;
      end
`endif
    end
  end

  // Port B: same behaviour as port A. The two ports are fully independent.
  always_comb begin
    w_rd_b = '0;
    if (rd_addr_b != 5'd0) begin
      w_rd_b = r_regs[rd_addr_b];
`ifdef WB_BYPASS_EN
      if (r_wb_we && (r_wb_addr == rd_addr_b)) begin
        w_rd_b = r_wb_data;
      end
`endif
    end
  end

  assign rd_data_a     = w_rd_a;
  assign rd_data_b     = w_rd_b;
  assign halted        = r_halted;
  assign retired_count = r_retired_count;
  assign wb_pending    = r_wb_we;

endmodule
`default_nettype wire

// File: tb/tb_writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_regfile
// Purpose  : Self-checking bench for writeback_regfile. It runs a directed
//            vector table, hand-written multi-cycle sequences (counter wrap,
//            reset over a pending write) and a randomized run compared
//            against an array-based reference model.
// Options  : follows WB_BYPASS_EN in step with the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_regfile;

`ifdef WB_BYPASS_EN
  localparam bit c_BYP = 1'b1;
`else
  localparam bit c_BYP = 1'b0;
`endif

  logic         clock;
  logic         reset;
  logic [180:0] EX_WB;
  logic [4:0]   rd_addr_a;
  logic [31:0]  rd_data_a;
  logic [4:0]   rd_addr_b;
  logic [31:0]  rd_data_b;
  logic         halted;
  logic [31:0]  retired_count;
  logic         wb_pending;

  writeback_regfile #(.DATA_W(32), .NREGS(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .EX_WB         (EX_WB),
    .rd_addr_a     (rd_addr_a),
    .rd_data_a     (rd_data_a),
    .rd_addr_b     (rd_addr_b),
    .rd_data_b     (rd_data_b),
    .halted        (halted),
    .retired_count (retired_count),
    .wb_pending    (wb_pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned m_regs [32];
  bit          m_pw;
  int unsigned m_pa;
  int unsigned m_pd;
  bit          m_halt;
  int unsigned m_cnt;

  function automatic bit is_writing(input int unsigned op);
    return (op >= 1 && op <= 8) || (op >= 11 && op <= 13);
  endfunction

  task automatic model_edge(input bit rst, input bit v, input int unsigned op,
                            input int unsigned dst, input int unsigned dat);
    if (rst) begin
      foreach (m_regs[k]) m_regs[k] = 0;
      m_pw = 0; m_pa = 0; m_pd = 0; m_halt = 0; m_cnt = 0;
    end else begin
      if (m_pw && m_pa != 0) m_regs[m_pa] = m_pd;
      if (v && !m_halt) begin
        m_cnt = m_cnt + 1;
        m_pw  = is_writing(op) && dst != 0;
        m_pa  = dst;
        m_pd  = dat;
        if (op == 14) m_halt = 1;
      end else begin
        m_pw = 0;
      end
    end
  endtask

  function automatic int unsigned model_read(input int unsigned addr);
    if (addr == 0) return 0;
    if (c_BYP && m_pw && m_pa == addr) return m_pd;
    return m_regs[addr];
  endfunction

  // ---------------- stimulus ----------------
  function automatic logic [180:0] bundle(input bit v, input logic [15:0] op,
                                          input logic [4:0] dst, input logic [31:0] dat);
    logic [180:0] ex;
    for (int k = 0; k < 181; k++) ex[k] = 1'($urandom_range(0, 1));
    ex[31:0]  = dat;
    ex[68:64] = dst;
    ex[69]    = v;
    ex[85:70] = op;
    return ex;
  endfunction

  // Drive one cycle at the falling edge, advance the model at the rising
  // edge, and return 1 ns later so that the caller can sample outputs.
  task automatic step(input bit rst, input bit v, input logic [15:0] op,
                      input logic [4:0] dst, input logic [31:0] dat,
                      input logic [4:0] ra, input logic [4:0] rb);
    @(negedge clock);
    reset     = rst;
    EX_WB     = bundle(v, op, dst, dat);
    rd_addr_a = ra;
    rd_addr_b = rb;
    @(posedge clock);
    model_edge(rst, v, op, dst, dat);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".rd_a"},  rd_data_a,     model_read(rd_addr_a));
    chk({tag, ".rd_b"},  rd_data_b,     model_read(rd_addr_b));
    chk({tag, ".halt"},  {31'd0, halted},     {31'd0, m_halt});
    chk({tag, ".count"}, retired_count, m_cnt);
    chk({tag, ".pend"},  {31'd0, wb_pending}, {31'd0, m_pw});
  endtask

  typedef struct {
    bit          v;
    logic [15:0] op;
    logic [4:0]  dst;
    logic [31:0] dat;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] ecnt;
    bit          eh;
    bit          ep;
  } vec_t;

  function automatic vec_t mk(bit v, logic [15:0] op, logic [4:0] dst, logic [31:0] dat,
                              logic [4:0] ra, logic [4:0] rb, logic [31:0] ea,
                              logic [31:0] eb, logic [31:0] ecnt, bit eh, bit ep);
    vec_t t;
    t.v = v; t.op = op; t.dst = dst; t.dat = dat; t.ra = ra; t.rb = rb;
    t.ea = ea; t.eb = eb; t.ecnt = ecnt; t.eh = eh; t.ep = ep;
    return t;
  endfunction

  vec_t tbl [12];

  initial begin
    reset = 1'b1; EX_WB = '0; rd_addr_a = '0; rd_addr_b = '0;

    // Directed table. Each row is one cycle, checked just after its edge.
    tbl[0]  = mk(1, 16'h1, 5, 32'h1234, 5, 0, c_BYP ? 32'h1234 : 32'h0, 0, 1, 0, 1);
    tbl[1]  = mk(0, 16'h0, 0, 32'h0, 5, 5, 32'h1234, 32'h1234, 1, 0, 0);
    tbl[2]  = mk(1, 16'h1, 0, 32'hFFFF_FFFF, 0, 5, 0, 32'h1234, 2, 0, 0);
    tbl[3]  = mk(1, 16'hF, 7, 32'h77, 7, 0, 0, 0, 3, 0, 0);
    tbl[4]  = mk(1, 16'h1, 3, 32'hA, 3, 3, c_BYP ? 32'hA : 32'h0, c_BYP ? 32'hA : 32'h0, 4, 0, 1);
    tbl[5]  = mk(1, 16'h2, 3, 32'hB, 3, 3, c_BYP ? 32'hB : 32'hA, c_BYP ? 32'hB : 32'hA, 5, 0, 1);
    tbl[6]  = mk(0, 16'h0, 0, 32'h0, 3, 3, 32'hB, 32'hB, 5, 0, 0);
    tbl[7]  = mk(1, 16'h10, 8, 32'h88, 8, 7, 0, 0, 6, 0, 0);
    tbl[8]  = mk(1, 16'hB, 4, 32'h44, 4, 4, c_BYP ? 32'h44 : 32'h0, c_BYP ? 32'h44 : 32'h0, 7, 0, 1);
    tbl[9]  = mk(1, 16'hE, 0, 32'h0, 4, 4, 32'h44, 32'h44, 8, 1, 0);
    tbl[10] = mk(1, 16'h1, 6, 32'h55, 6, 4, 0, 32'h44, 8, 1, 0);
    tbl[11] = mk(0, 16'h0, 0, 32'h0, 6, 6, 0, 0, 8, 1, 0);

    // Reset state: every address reads zero.
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i);
      rd_addr_b = 5'(31 - i);
      #1;
      chk("reset.rd_a", rd_data_a, 0);
      chk("reset.rd_b", rd_data_b, 0);
    end
    chk("reset.count", retired_count, 0);
    chk("reset.halt", {31'd0, halted}, 0);
    chk("reset.pend", {31'd0, wb_pending}, 0);

    for (int i = 0; i < 12; i++) begin
      step(0, tbl[i].v, tbl[i].op, tbl[i].dst, tbl[i].dat, tbl[i].ra, tbl[i].rb);
      chk($sformatf("tbl%0d.rd_a", i), rd_data_a, tbl[i].ea);
      chk($sformatf("tbl%0d.rd_b", i), rd_data_b, tbl[i].eb);
      chk($sformatf("tbl%0d.count", i), retired_count, tbl[i].ecnt);
      chk($sformatf("tbl%0d.halt", i), {31'd0, halted}, {31'd0, tbl[i].eh});
      chk($sformatf("tbl%0d.pend", i), {31'd0, wb_pending}, {31'd0, tbl[i].ep});
    end

    // Only reset clears halt.
    step(1, 0, 0, 0, 0, 0, 0);
    chk("unhalt.halt", {31'd0, halted}, 0);
    chk("unhalt.rd4", rd_data_a, 0);

    // Counter wrap: preset the counter to all ones, then retire one NOP.
    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    force dut.r_retired_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired_count;
    step(0, 1, 16'hF, 2, 32'h5, 0, 0);
    chk("wrap.count", retired_count, 32'h0);
    m_cnt = 0;

    // A reset on the edge after a capture drops the pending write.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 16'h1, 9, 32'h99, 9, 9);
    chk("rstpend.pend1", {31'd0, wb_pending}, 1);
    chk("rstpend.rd_a1", rd_data_a, c_BYP ? 32'h99 : 32'h0);
    step(1, 0, 0, 0, 0, 9, 9);
    chk("rstpend.pend2", {31'd0, wb_pending}, 0);
    chk("rstpend.rd_a2", rd_data_a, 0);
    step(0, 0, 0, 0, 0, 9, 9);
    chk("rstpend.rd_a3", rd_data_a, 0);
    chk("rstpend.rd_b3", rd_data_b, 0);

    // Randomized run compared against the reference model.
    step(1, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 800; n++) begin
      bit          rst;
      bit          v;
      logic [15:0] op;
      logic [4:0]  dst;
      logic [4:0]  ra;
      logic [4:0]  rb;
      int unsigned sel;
      rst = ($urandom_range(0, 59) == 0);
      v   = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 99);
      if (sel < 2)       op = 16'hE;
      else if (sel < 8)  op = 16'($urandom);
      else begin
        op = 16'($urandom_range(0, 16));
        if (op == 16'hE) op = 16'h1;
      end
      dst = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      ra  = 5'($urandom_range(0, 7));
      rb  = ($urandom_range(0, 1) != 0) ? ra : 5'($urandom_range(0, 31));
      step(rst, v, op, dst, $urandom, ra, rb);
      chk_model($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
